// File: rtl/uartcon_rx.sv
// UART receiver for the debug UART: 8N1 frames at a fixed CLKS_PER_BIT clocks per bit.
// Each received byte is held in an output register and offered through a valid/load handshake.
module uartcon_rx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic       valid,
    input  logic       load,
    output logic [7:0] data,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rxd_s;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;

    // Synchroniser presets to the idle level so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rxd};
        end
    end

    assign rxd_s = sync[SYNC_STAGES-1];

    // Frame FSM with registered outputs; error pulses default low every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            valid     <= 1'b0;
            data      <= 8'h00;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            if (load && valid) begin
                valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!rxd_s) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end

                S_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            state <= S_IDLE;
                        end else begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                S_DATA: begin
                    if (cnt == CNT_BIT) begin
                        cnt     <= '0;
                        shreg   <= {rxd_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                // Leaving at the stop-bit midpoint re-arms half a bit early for back-to-back frames
                S_STOP: begin
                    if (cnt == CNT_BIT) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            state <= S_IDLE;
                            if (!valid || load) begin
                                data  <= shreg;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                S_BREAK: begin
                    if (rxd_s) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
